// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronizes and debounces raw coin sensors, then turns
// validated coin events into clean one-cycle nickel/dime pulses, buffering
// one coin while the downstream FSM holds and returning coins it cannot take.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic nickel_raw,
  input  logic dime_raw,
  input  logic hold,
  output logic nickel,
  output logic dime,
  output logic coin_return,
  output logic pending
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned N_CH     = 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CNT = 2'd1,
    HIGH     = 2'd2,
    FALL_CNT = 2'd3
  } db_state_t;

  // Channel 0 is nickel, channel 1 is dime.
  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  db_state_t       db_state_q [N_CH];
  db_state_t       db_state_d [N_CH];
  logic [CNT_W-1:0] cnt_q     [N_CH];
  logic [CNT_W-1:0] cnt_d     [N_CH];
  logic [N_CH-1:0] ev_q;
  logic [N_CH-1:0] ev_d;

  logic pend_v_q, pend_v_d;
  logic pend_t_q, pend_t_d;   // buffered coin type: 0 nickel, 1 dime
  logic nickel_d, dime_d, coin_return_d;

  logic ev_one;
  logic ev_both;
  logic ev_t;

  // Two-flop synchronizers for the asynchronous sensor levels.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {dime_raw, nickel_raw};
      sync2_q <= sync1_q;
    end
  end

  // Debouncer state, counters and registered rise events.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        db_state_q[i] <= LOW;
        cnt_q[i]      <= '0;
      end
      ev_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        db_state_q[i] <= db_state_d[i];
        cnt_q[i]      <= cnt_d[i];
      end
      ev_q <= ev_d;
    end
  end

  // Debouncer next state: a level must hold DEBOUNCE_CYCLES samples; event only on rise.
  always_comb begin
    ev_d = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      db_state_d[i] = db_state_q[i];
      cnt_d[i]      = cnt_q[i];
      case (db_state_q[i])
        LOW: begin
          if (sync2_q[i]) begin
            if (CNT_MAX <= CNT_W'(1)) begin
              db_state_d[i] = HIGH;
              cnt_d[i]      = '0;
              ev_d[i]       = 1'b1;
            end else begin
              db_state_d[i] = RISE_CNT;
              cnt_d[i]      = CNT_W'(1);
            end
          end
        end
        RISE_CNT: begin
          if (!sync2_q[i]) begin
            db_state_d[i] = LOW;
            cnt_d[i]      = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            db_state_d[i] = HIGH;
            cnt_d[i]      = '0;
            ev_d[i]       = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!sync2_q[i]) begin
            if (CNT_MAX <= CNT_W'(1)) begin
              db_state_d[i] = LOW;
              cnt_d[i]      = '0;
            end else begin
              db_state_d[i] = FALL_CNT;
              cnt_d[i]      = CNT_W'(1);
            end
          end
        end
        FALL_CNT: begin
          if (sync2_q[i]) begin
            db_state_d[i] = HIGH;
            cnt_d[i]      = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            db_state_d[i] = LOW;
            cnt_d[i]      = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          db_state_d[i] = LOW;
          cnt_d[i]      = '0;
        end
      endcase
    end
  end

  assign ev_one  = ev_q[0] ^ ev_q[1];
  assign ev_both = ev_q[0] & ev_q[1];
  assign ev_t    = ev_q[1];

  // Output/buffer stage: release buffered coin first, buffer or reject new ones under hold.
  always_comb begin
    pend_v_d      = pend_v_q;
    pend_t_d      = pend_t_q;
    nickel_d      = 1'b0;
    dime_d        = 1'b0;
    coin_return_d = 1'b0;

    if (ev_both) begin
      coin_return_d = 1'b1;
    end

    if (pend_v_q && !hold) begin
      nickel_d = ~pend_t_q;
      dime_d   = pend_t_q;
      if (ev_one) begin
        pend_t_d = ev_t;
      end else begin
        pend_v_d = 1'b0;
      end
    end else if (pend_v_q && hold) begin
      if (ev_one) begin
        coin_return_d = 1'b1;
      end
    end else if (ev_one && !hold) begin
      nickel_d = ~ev_t;
      dime_d   = ev_t;
    end else if (ev_one && hold) begin
      pend_v_d = 1'b1;
      pend_t_d = ev_t;
    end
  end

  // Registered outputs and pending buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_v_q    <= 1'b0;
      pend_t_q    <= 1'b0;
      nickel      <= 1'b0;
      dime        <= 1'b0;
      coin_return <= 1'b0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_t_q    <= pend_t_d;
      nickel      <= nickel_d;
      dime        <= dime_d;
      coin_return <= coin_return_d;
    end
  end

  assign pending = pend_v_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed stimulus pushes expected pulses into a queue;
// a negedge monitor pops and compares every pulse the DUT presents.
module tb_coin_acceptor;

  localparam int unsigned D   = 4;
  localparam int          LAT = int'(D) + 3;

  localparam logic [2:0] K_NICKEL = 3'b001;
  localparam logic [2:0] K_DIME   = 3'b010;
  localparam logic [2:0] K_RETURN = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } exp_t;

  logic clock;
  logic reset;
  logic nickel_raw;
  logic dime_raw;
  logic hold;
  logic nickel;
  logic dime;
  logic coin_return;
  logic pending;

  int   cyc;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  coin_acceptor #(.DEBOUNCE_CYCLES(D)) dut (
    .clock       (clock),
    .reset       (reset),
    .nickel_raw  (nickel_raw),
    .dime_raw    (dime_raw),
    .hold        (hold),
    .nickel      (nickel),
    .dime        (dime),
    .coin_return (coin_return),
    .pending     (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: flag overdue expectations, then match any presented pulse.
  always @(negedge clock) begin
    logic [2:0] obs;
    exp_t       e;
    obs = {coin_return, dime, nickel};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_pulse: expected kind=%b at cycle %0d, not seen by cycle %0d", e.kind, e.cyc, cyc);
    end
    if (obs != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got kind=%b at cycle %0d, expected none", obs, cyc);
      end else begin
        e = exp_q.pop_front();
        if (obs != e.kind || cyc != e.cyc) begin
          failures++;
          $display("FAIL pulse: got kind=%b at cycle %0d, expected kind=%b at cycle %0d", obs, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic expect_pulse(input logic [2:0] kind, input int at_cyc);
    exp_t e;
    e.kind = kind;
    e.cyc  = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic check_bits(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    int t0;
    cyc        = 0;
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    nickel_raw = 1'b0;
    dime_raw   = 1'b0;
    hold       = 1'b0;

    // Reset state
    wait_neg(3);
    check_bits("reset_outputs", {nickel, dime, coin_return, pending}, 4'b0000);
    reset = 1'b1;
    wait_neg(3);

    // Clean nickel, held long: one pulse after edge D+3, none on release
    t0 = cyc;
    nickel_raw = 1'b1;
    expect_pulse(K_NICKEL, t0 + LAT);
    wait_neg(20);
    nickel_raw = 1'b0;
    wait_neg(15);

    // Bouncy dime: 1,0,1,1,0 then steady high
    t0 = cyc;
    dime_raw = 1'b1; wait_neg(1);
    dime_raw = 1'b0; wait_neg(1);
    dime_raw = 1'b1; wait_neg(1);
    dime_raw = 1'b1; wait_neg(1);
    dime_raw = 1'b0; wait_neg(1);
    dime_raw = 1'b1;
    expect_pulse(K_DIME, t0 + 5 + LAT);
    wait_neg(20);
    dime_raw = 1'b0;
    wait_neg(15);

    // Simultaneous coins are returned
    t0 = cyc;
    nickel_raw = 1'b1;
    dime_raw   = 1'b1;
    expect_pulse(K_RETURN, t0 + LAT);
    wait_neg(10);
    nickel_raw = 1'b0;
    dime_raw   = 1'b0;
    wait_neg(15);

    // Dime buffered under hold, released the cycle after hold drops
    hold     = 1'b1;
    dime_raw = 1'b1;
    wait_neg(10);
    check_bits("pend_dime_held", {nickel, dime, coin_return, pending}, 4'b0001);
    hold = 1'b0;
    expect_pulse(K_DIME, cyc + 1);
    wait_neg(2);
    check_bits("pend_dime_cleared", {nickel, dime, coin_return, pending}, 4'b0000);
    dime_raw = 1'b0;
    wait_neg(15);

    // Pending nickel, second coin (dime) under hold is returned
    hold       = 1'b1;
    nickel_raw = 1'b1;
    wait_neg(10);
    check_bits("pend_nickel_held", {nickel, dime, coin_return, pending}, 4'b0001);
    nickel_raw = 1'b0;
    wait_neg(10);
    t0 = cyc;
    dime_raw = 1'b1;
    expect_pulse(K_RETURN, t0 + LAT);
    wait_neg(10);
    check_bits("pend_after_return", {nickel, dime, coin_return, pending}, 4'b0001);
    dime_raw = 1'b0;
    wait_neg(10);
    hold = 1'b0;
    expect_pulse(K_NICKEL, cyc + 1);
    wait_neg(3);
    check_bits("pend_nickel_released", {nickel, dime, coin_return, pending}, 4'b0000);
    wait_neg(5);

    // Reset while a coin is pending: discarded, no return
    hold       = 1'b1;
    nickel_raw = 1'b1;
    wait_neg(10);
    check_bits("pend_before_reset", {nickel, dime, coin_return, pending}, 4'b0001);
    reset = 1'b0;
    #1;
    check_bits("reset_clears_pending", {nickel, dime, coin_return, pending}, 4'b0000);
    wait_neg(1);
    hold = 1'b0;
    wait_neg(2);

    // Release with nickel still high, then reset again mid RISE_CNT
    reset = 1'b1;
    wait_neg(4);
    reset = 1'b0;
    #1;
    check_bits("reset_mid_rise", {nickel, dime, coin_return, pending}, 4'b0000);
    wait_neg(2);
    t0 = cyc;
    reset = 1'b1;
    expect_pulse(K_NICKEL, t0 + LAT);
    wait_neg(20);
    nickel_raw = 1'b0;
    wait_neg(15);

    // Every expected pulse must have been consumed
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d expected pulses outstanding, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
